// File: rtl/bcd_subtractor_serial.sv
// bcd_subtractor_serial: digit-serial packed-BCD subtractor, |a-b| plus sign.
// Optional input digit check enabled by defining BCD_CHECK_EN (adds err port).
module bcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] diff,
    output logic                neg
`ifdef BCD_CHECK_EN
    ,
    output logic                err
`endif
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] NEG  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [W-1:0]  res;
    logic [IW-1:0] idx;
    logic          borrow;
    logic          neg_q;
    logic          bad;

    logic [3:0]    dx;
    logic [3:0]    dy;
    logic [4:0]    t;
    logic [4:0]    tc;
    logic [3:0]    dout;
    logic          bout;

`ifdef BCD_CHECK_EN
    logic          err_q;

    function automatic logic has_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    assign bad = err_q;
`else
    assign bad = 1'b0;
`endif

    // Shared digit stage: SUB takes a_i - b_i, NEG takes 0 - res_i (ten's complement).
    always_comb begin
        dx = 4'd0;
        dy = 4'd0;
        if (state == SUB) begin
            dx = opa[4*idx +: 4];
            dy = opb[4*idx +: 4];
        end else begin
            dx = 4'd0;
            dy = res[4*idx +: 4];
        end
        t    = {1'b0, dx} - {1'b0, dy} - {4'd0, borrow};
        tc   = t + 5'd10;
        bout = t[4];
        dout = bout ? tc[3:0] : t[3:0];
    end

    // Control FSM and result register, one digit per cycle in SUB and NEG.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            neg_q  <= 1'b0;
`ifdef BCD_CHECK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa    <= a;
                        opb    <= b;
                        idx    <= '0;
                        borrow <= 1'b0;
                        state  <= SUB;
`ifdef BCD_CHECK_EN
                        err_q  <= has_bad(a) | has_bad(b);
`endif
                    end
                end
                SUB: begin
                    res[4*idx +: 4] <= dout;
                    if (idx == LAST) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                        if (bout && !bad) begin
                            state <= NEG;
                        end else begin
                            neg_q <= 1'b0;
                            state <= DONE;
                        end
                    end else begin
                        idx    <= idx + 1'b1;
                        borrow <= bout;
                    end
                end
                NEG: begin
                    res[4*idx +: 4] <= dout;
                    if (idx == LAST) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                        neg_q  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx    <= idx + 1'b1;
                        borrow <= bout;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

`ifdef BCD_CHECK_EN
    assign diff = err_q ? '0 : res;
    assign neg  = neg_q & ~err_q;
    assign err  = err_q;
`else
    assign diff = res;
    assign neg  = neg_q;
`endif

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// tb_bcd_subtractor_serial: directed and random checks of the serial BCD
// subtractor against an integer-arithmetic reference model.
module tb_bcd_subtractor_serial;

    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         neg;
`ifdef BCD_CHECK_EN
    logic         err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .neg       (neg)
`ifdef BCD_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // One transaction with out_ready as currently set; returns at the
    // negedge where out_valid is first seen, with latency in negedges.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output logic [W-1:0] d, output logic n,
                         output int lat, output logic e);
        @(negedge clk);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 100);
        if (lat >= 100) chk("timeout", 32'd0, 32'd1);
        d = diff;
        n = neg;
`ifdef BCD_CHECK_EN
        e = err;
`else
        e = 1'b0;
`endif
    endtask

    task automatic model_op(input string tag, input logic [W-1:0] xa,
                            input logic [W-1:0] xb);
        logic [W-1:0] d;
        logic n;
        logic e;
        int lat;
        int va;
        int vb;
        int r;
        va = bcd2int(xa);
        vb = bcd2int(xb);
        r = va - vb;
        do_op(xa, xb, d, n, lat, e);
        chk({tag, "_diff"}, 32'(d), 32'(int2bcd(r < 0 ? -r : r)));
        chk({tag, "_neg"}, 32'(n), (r < 0) ? 32'd1 : 32'd0);
        chk({tag, "_lat"}, 32'(lat), (r < 0) ? 32'(2*DIGITS+1) : 32'(DIGITS+1));
        chk({tag, "_err"}, 32'(e), 32'd0);
        @(negedge clk);
        chk({tag, "_ovdrop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic n;
        logic e;
        logic seen;
        int lat;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
`ifdef BCD_CHECK_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        rst = 1'b0;

        model_op("pos", 16'h5123, 16'h1234);
        model_op("negv", 16'h1234, 16'h5123);
        model_op("zm1", 16'h0000, 16'h0001);
        model_op("eq9", 16'h9999, 16'h9999);
        model_op("zero", 16'h0000, 16'h0000);
        model_op("max", 16'h9999, 16'h0000);
        model_op("min", 16'h0000, 16'h9999);

        // backpressure: result held, new operands wait for the handshake
        out_ready = 1'b0;
        do_op(16'h0100, 16'h0001, d, n, lat, e);
        chk("bp_diff", 32'(d), 32'h0099);
        chk("bp_neg", 32'(n), 32'd0);
        a = 16'h2222;
        b = 16'h1111;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_ov", 32'(out_valid), 32'd1);
            chk("bp_hold_diff", 32'(diff), 32'h0099);
            chk("bp_hold_neg", 32'(neg), 32'd0);
            chk("bp_hold_inrdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ov", 32'(out_valid), 32'd0);
        chk("bp_rel_inrdy", 32'(in_ready), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 100);
        chk("bp_next_diff", 32'(diff), 32'h1111);
        chk("bp_next_lat", 32'(lat), 32'(DIGITS+1));
        @(negedge clk);

        // reset during SUB digit 2 aborts the operation
        a = 16'h4321;
        b = 16'h1111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_inrdy", 32'(in_ready), 32'd1);
        chk("abort_ov", 32'(out_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_noresult", 32'(seen), 32'd0);

`ifdef BCD_CHECK_EN
        do_op(16'h12A4, 16'h0001, d, n, lat, e);
        chk("bad_err", 32'(e), 32'd1);
        chk("bad_diff", 32'(d), 32'd0);
        chk("bad_neg", 32'(n), 32'd0);
        chk("bad_lat", 32'(lat), 32'(DIGITS+1));
        @(negedge clk);
        model_op("after_bad", 16'h0010, 16'h0001);
`else
        do_op(16'h000F, 16'h0000, d, n, lat, e);
        chk("nonbcd_f_diff", 32'(d), 32'h000F);
        chk("nonbcd_f_neg", 32'(n), 32'd0);
        @(negedge clk);
        do_op(16'h00A0, 16'h0001, d, n, lat, e);
        chk("nonbcd_a_diff", 32'(d), 32'h0099);
        chk("nonbcd_a_neg", 32'(n), 32'd0);
        @(negedge clk);
`endif

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < DIGITS; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) rb = ra;
            model_op("rand", ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
